button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 33 +++
 rtl/button_channel.sv | 155 +++++++++++++++
 rtl/button_conditioner.sv | 54 +++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared definitions for the button conditioner: the per-channel
//            FSM state encoding, default parameter values and a helper that
//            sizes counters for a given maximum value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  localparam int DEF_N_CH          = 5;
  localparam int DEF_DB_CYCLES     = 4;
  localparam int DEF_LONG_CYCLES   = 8;
  localparam int DEF_REPEAT_CYCLES = 3;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_channel
// Purpose  : One button channel: debounce FSM, press/release edge pulses,
//            long-press hold detection and auto-repeat pulse generation.
// Ports    : clk           - clock, all state on rising edge
//            rst           - synchronous active-high reset
//            button        - raw synchronised button level (1 = pressed)
//            level         - debounced level
//            press         - one-cycle pulse on debounced rising edge
//            release_pulse - one-cycle pulse on debounced falling edge
//            hold          - long-press level
//            rpt           - auto-repeat pulses while hold is high
// Revision : 1.0 - initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic hold,
  output logic rpt
);

  localparam int DB_W   = cnt_width(DB_CYCLES);
  localparam int LONG_W = cnt_width(LONG_CYCLES);
  localparam int RPT_W  = cnt_width(REPEAT_CYCLES - 1);

  // Debounce count reaching DB_LAST means this sample is the DB_CYCLES-th.
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  btn_state_t        state;
  btn_state_t        state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic [LONG_W-1:0] long_cnt;
  logic [RPT_W-1:0]  rpt_cnt;
  logic              level_q;

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      IDLE: begin
        if (button) begin
          if (DB_CYCLES == 1) begin
            state_nxt = PRESSED;
          end else begin
            state_nxt  = ARMING;
            db_cnt_nxt = DB_W'(1);
          end
        end
      end
      ARMING: begin
        if (!button) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!button) begin
          if (DB_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = RELEASING;
            db_cnt_nxt = DB_W'(1);
          end
        end
      end
      RELEASING: begin
        // A return to 1 is a bounce: level never dropped, so no press pulse.
        if (button) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // Level comes straight from the state register, so it is glitch-free and
  // stays high through RELEASING bounces.
  assign level = (state == PRESSED) || (state == RELEASING);

  // --------------------------------------------------------------------------
  // Edge, hold and repeat tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Clearing level_q with the FSM keeps reset from looking like a release.
      level_q  <= 1'b0;
      long_cnt <= '0;
      rpt_cnt  <= '0;
    end else begin
      level_q <= level;

      if (!level) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_MAX) begin
        long_cnt <= long_cnt + 1'b1;
      end

      if (!hold || (rpt_cnt == RPT_LAST)) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign press         = level && !level_q;
  assign release_pulse = !level && level_q;
  // Both qualified by level so they drop in the same cycle level does.
  assign hold          = level && (long_cnt == LONG_MAX);
  assign rpt           = hold && (rpt_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : N_CH independent button channels, each debounced and decoded
//            into level, press/release pulses, long-press hold and repeat.
// Ports    : clk           - clock, all state on rising edge
//            rst           - synchronous active-high reset
//            button        - [N_CH] raw synchronised button levels
//            level         - [N_CH] debounced levels
//            press         - [N_CH] debounced rising-edge pulses
//            release_pulse - [N_CH] debounced falling-edge pulses
//                            ("release" is a reserved word in SystemVerilog)
//            hold          - [N_CH] long-press levels
//            rpt           - [N_CH] auto-repeat pulses
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .button       (button[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .hold         (hold[i]),
      .rpt          (rpt[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner (2 channels). Directed
//            scenarios followed by random button segments, compared every
//            cycle against a run-length reference model of each channel.
// Ports    : none (testbench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N_CH = 2;
  localparam int DB   = 4;
  localparam int LONG = 8;
  localparam int RPT  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] hold;
  logic [N_CH-1:0] rpt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: per channel, length of the current run of identical
  // samples, the debounced level and how many cycles it has been high.
  int   streak [N_CH];
  logic last_b [N_CH];
  logic m_lvl  [N_CH];
  logic m_prev [N_CH];
  int   m_run  [N_CH];

  button_conditioner #(
    .N_CH         (N_CH),
    .DB_CYCLES    (DB),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .hold         (hold),
    .rpt          (rpt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [N_CH-1:0] b);
    for (int c = 0; c < N_CH; c++) begin
      if (r) begin
        streak[c] = 0;
        last_b[c] = 1'b0;
        m_lvl[c]  = 1'b0;
        m_prev[c] = 1'b0;
        m_run[c]  = 0;
      end else begin
        if (streak[c] > 0 && last_b[c] == b[c]) streak[c]++;
        else streak[c] = 1;
        last_b[c] = b[c];
        m_prev[c] = m_lvl[c];
        // Level follows the input once it has been steady for DB samples.
        if (b[c] != m_lvl[c] && streak[c] >= DB) m_lvl[c] = b[c];
        if (m_lvl[c]) m_run[c] = m_prev[c] ? m_run[c] + 1 : 0;
        else m_run[c] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0] e_lvl, e_prs, e_rel, e_hld, e_rpt;
    for (int c = 0; c < N_CH; c++) begin
      e_lvl[c] = m_lvl[c];
      e_prs[c] = m_lvl[c] && !m_prev[c];
      e_rel[c] = !m_lvl[c] && m_prev[c];
      e_hld[c] = m_lvl[c] && (m_run[c] >= LONG);
      e_rpt[c] = e_hld[c] && (((m_run[c] - LONG) % RPT) == 0);
    end
    check_val("level",   32'(level),         32'(e_lvl));
    check_val("press",   32'(press),         32'(e_prs));
    check_val("release", 32'(release_pulse), 32'(e_rel));
    check_val("hold",    32'(hold),          32'(e_hld));
    check_val("rpt",     32'(rpt),           32'(e_rpt));
  endtask

  // Drive one cycle of inputs, advance the model at the edge and compare the
  // resulting outputs half a cycle later.
  task automatic step(input logic r, input logic [N_CH-1:0] b);
    rst    = r;
    button = b;
    @(posedge clk);
    model_step(r, b);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int first_lvl, first_hold, n_press, n_rel, n_rpt;
    logic [N_CH-1:0] cur;
    int seg [N_CH];
    logic [7:0] pat;

    rst    = 1'b1;
    button = '0;
    for (int c = 0; c < N_CH; c++) begin
      streak[c] = 0; last_b[c] = 1'b0; m_lvl[c] = 1'b0; m_prev[c] = 1'b0; m_run[c] = 0;
    end
    repeat (3) step(1'b1, 2'b00);
    check_val("rst_all_zero", 32'({level, press, release_pulse, hold, rpt}), 32'd0);

    // Held press on channel 0 with exact timing landmarks.
    first_lvl = -1; first_hold = -1; n_press = 0; n_rpt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 2'b01);
      if (level[0] && first_lvl < 0) first_lvl = k + 1;
      if (hold[0] && first_hold < 0) first_hold = k + 1;
      n_press += int'(press[0]);
      n_rpt   += int'(rpt[0]);
    end
    check_val("held_first_level", 32'(first_lvl), 32'd4);
    check_val("held_first_hold",  32'(first_hold), 32'd12);
    check_val("held_press_count", 32'(n_press), 32'd1);
    check_val("held_rpt_count",   32'(n_rpt), 32'd7);
    check_val("ch1_idle",         32'(level[1]), 32'd0);

    n_rel = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b00);
      n_rel += int'(release_pulse[0]);
      if (release_pulse[0]) check_val("release_no_rpt", 32'(rpt[0]), 32'd0);
    end
    check_val("release_count", 32'(n_rel), 32'd1);

    // Broken run of 1s: press only after four consecutive samples.
    pat = 8'b1111_0111;
    n_press = 0; first_lvl = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, {1'b0, pat[k]});
      n_press += int'(press[0]);
      if (press[0] && first_lvl < 0) first_lvl = k + 1;
    end
    check_val("pattern_press_at", 32'(first_lvl), 32'd8);
    check_val("pattern_press_cnt", 32'(n_press), 32'd1);
    repeat (10) step(1'b0, 2'b00);

    // Short glitch while pressed and holding.
    repeat (14) step(1'b0, 2'b01);
    n_press = 0; n_rel = 0;
    repeat (2) begin
      step(1'b0, 2'b00);
      n_rel += int'(release_pulse[0]);
    end
    repeat (10) begin
      step(1'b0, 2'b01);
      n_press += int'(press[0]);
      n_rel   += int'(release_pulse[0]);
    end
    check_val("glitch_no_edges", 32'(n_press + n_rel), 32'd0);
    check_val("glitch_hold_kept", 32'(hold[0]), 32'd1);
    repeat (8) step(1'b0, 2'b00);

    // Reset during hold with button kept pressed.
    repeat (15) step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    check_val("rst_during_hold", 32'({level, press, release_pulse, hold, rpt}), 32'd0);
    first_lvl = -1; n_rel = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 2'b01);
      n_rel += int'(release_pulse[0]);
      if (press[0] && first_lvl < 0) first_lvl = k + 1;
    end
    check_val("rst_then_press_at", 32'(first_lvl), 32'd4);
    check_val("rst_no_release", 32'(n_rel), 32'd0);
    repeat (8) step(1'b0, 2'b00);

    // Both channels pressed with offset timing.
    repeat (2) step(1'b0, 2'b01);
    repeat (20) step(1'b0, 2'b11);
    repeat (3) step(1'b0, 2'b10);
    repeat (10) step(1'b0, 2'b00);

    // Random segments: mixes sub-debounce bounces with long holds.
    cur = '0;
    for (int c = 0; c < N_CH; c++) seg[c] = 0;
    repeat (1500) begin
      for (int c = 0; c < N_CH; c++) begin
        if (seg[c] == 0) begin
          cur[c] = ~cur[c];
          if ($urandom_range(0, 1) == 0) seg[c] = int'($urandom_range(1, DB));
          else seg[c] = int'($urandom_range(DB, 3 * LONG));
        end
        seg[c]--;
      end
      step($urandom_range(0, 199) == 0, cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
